// File: rtl/baud_gen_os_pkg.sv
// Shared definitions for the oversampling baud generator.
//   baud_div_t   : divisor as {int_part, frac_part}
//   default_div(): reset-time divisor from clock rate, baud rate,
//                  oversample factor and fractional width
package baud_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef struct packed {
    logic [63:0] int_part;
    logic [63:0] frac_part;
  } baud_div_t;

  // All arithmetic is 64-bit so that the fractional scaling does not overflow.
  function automatic baud_div_t default_div(input longint unsigned clk_hz,
                                            input longint unsigned baudrate,
                                            input longint unsigned oversample,
                                            input int unsigned     frac_w);
    longint unsigned tick_hz;
    baud_div_t       d;
    tick_hz     = baudrate * oversample;
    d.int_part  = clk_hz / tick_hz;
    d.frac_part = ((clk_hz << frac_w) / tick_hz) % (64'd1 << frac_w);
    return d;
  endfunction

endpackage

// File: rtl/baud_gen_os_if.sv
// Programming and tick interface of the oversampling baud generator.
//   master : register block / FSM side (drives divisor, load, restarts)
//   slave  : baud generator side (drives ticks and busy)
// Signals:
//   i_div_int    integer clocks per oversample tick
//   i_div_frac   fractional part, units of 1/2^FRAC_W clock
//   i_div_load   one-cycle strobe capturing the divisor into the pending register
//   i_tx_restart clears the TX phase
//   i_rx_restart clears the RX phase
//   o_os_tick    oversample tick pulse
//   o_tx_tick    one pulse per bit
//   o_rx_sample  mid-bit sample pulse
//   o_div_busy   loaded divisor pending, not yet active
interface baud_gen_os_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic [DIV_W-1:0]  i_div_int;
  logic [FRAC_W-1:0] i_div_frac;
  logic              i_div_load;
  logic              i_tx_restart;
  logic              i_rx_restart;
  logic              o_os_tick;
  logic              o_tx_tick;
  logic              o_rx_sample;
  logic              o_div_busy;

  modport master (
    output i_div_int, i_div_frac, i_div_load, i_tx_restart, i_rx_restart,
    input  o_os_tick, o_tx_tick, o_rx_sample, o_div_busy
  );

  modport slave (
    input  i_div_int, i_div_frac, i_div_load, i_tx_restart, i_rx_restart,
    output o_os_tick, o_tx_tick, o_rx_sample, o_div_busy
  );
endinterface

// File: rtl/baud_gen_os_phase_ctr.sv
// Phase counter for one derived tick stream (TX bit tick or RX mid-bit sample).
// Counts oversample periods 0..OVERSAMPLE-1 and emits a registered pulse,
// aligned with the registered os tick, on the wrap whose pre-increment phase
// equals HIT_POINT.
// Ports:
//   i_clk   clock
//   reset   synchronous active-high reset
//   restart clear phase to 0; suppresses a hit in the same cycle
//   os_tick period-wrap strobe (combinational, one cycle before o_os_tick)
//   hit     registered one-cycle pulse
module baud_phase_ctr
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int HIT_POINT  = OVERSAMPLE - 1
) (
  input  logic i_clk,
  input  logic reset,
  input  logic restart,
  input  logic os_tick,
  output logic hit
);

  localparam int              PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] HIT  = PH_W'(HIT_POINT);

  logic [PH_W-1:0] phase;

  // NOTE: registers use non-blocking assignments so every update in this
  // block sees the pre-edge phase value, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      phase <= '0;
      hit   <= 1'b0;
    end else if (restart) begin
      phase <= '0;
      hit   <= 1'b0;
    end else begin
      hit <= os_tick && (phase == HIT);
      // OVERSAMPLE is a power of two, so the natural wrap is the modulo.
      if (os_tick) phase <= phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_os.sv
// Oversampling baud tick generator with runtime-programmable divisor.
// Produces an oversample tick, a per-bit TX tick and a mid-bit RX sample tick;
// TX and RX phases restart independently.
// Ports:
//   i_clk  clock
//   reset  synchronous active-high reset
//   bus    baud_gen_os_if.slave (divisor load, restarts, ticks, busy)
// Build option:
//   BAUD_GEN_FRAC_EN defined   -> fractional accumulator stretches periods by
//                                 one clock on accumulator overflow.
//   BAUD_GEN_FRAC_EN undefined -> period is exactly the integer divisor;
//                                 i_div_frac is ignored.
module baud_gen_os
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUDRATE   = 921600,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int          DIV_W      = 16,
  parameter int          FRAC_W     = 4
) (
  input logic          i_clk,
  input logic          reset,
  baud_gen_os_if.slave bus
);

  localparam baud_div_t DEF_DIV = default_div(64'(CLK_HZ), 64'(BAUDRATE),
                                              64'(OVERSAMPLE), FRAC_W);
  localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DEF_DIV.int_part);

  if (DEF_DIV.int_part < 64'd2 || DEF_DIV.int_part >= (64'd1 << DIV_W)) begin : g_bad_default
    $error("baud_gen_os: default integer divisor out of range");
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("baud_gen_os: OVERSAMPLE must be a power of two >= 4");
  end

  logic [DIV_W-1:0] c;          // position within the current period
  logic [DIV_W-1:0] act_int;    // divisor in use
  logic [DIV_W-1:0] pend_int;   // divisor waiting for the next wrap
  logic             busy_q;
  logic             os_tick_q;

  logic [DIV_W-1:0] eff_int;
  logic [DIV_W:0]   last_c;
  logic             carry;
  logic             at_end;
  logic             both_restart;
  logic             wrap;

  // Divisors below 2 cannot produce a distinct tick cycle, so they run at 2.
  assign eff_int = (act_int < DIV_W'(2)) ? DIV_W'(2) : act_int;

`ifdef BAUD_GEN_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV.frac_part);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W:0]   frac_sum;

  // The carry only matters at c == P-1; acc is stable across the period,
  // so evaluating it every cycle gives the same P throughout.
  assign frac_sum = {1'b0, acc} + {1'b0, act_frac};
  assign carry    = frac_sum[FRAC_W];

  always_ff @(posedge i_clk) begin
    if (reset) begin
      acc       <= '0;
      act_frac  <= DEF_FRAC;
      pend_frac <= DEF_FRAC;
    end else begin
      if (both_restart) begin
        acc <= '0;
      end else if (at_end) begin
        acc <= frac_sum[FRAC_W-1:0];
        if (busy_q) act_frac <= pend_frac;
      end
      if (bus.i_div_load) pend_frac <= bus.i_div_frac;
    end
  end
`else
  logic unused_div_frac;
  assign unused_div_frac = ^bus.i_div_frac;
  assign carry           = 1'b0;
`endif

  assign last_c       = {1'b0, eff_int} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
  assign at_end       = ({1'b0, c} == last_c);
  // Both restarts together restart the period, so that cycle never wraps.
  assign both_restart = bus.i_tx_restart & bus.i_rx_restart;
  assign wrap         = at_end & ~both_restart;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      c         <= '0;
      os_tick_q <= 1'b0;
      busy_q    <= 1'b0;
      // NOTE: divisor registers reset to the computed defaults rather than
      // zero so the generator ticks at the nominal rate straight out of reset.
      act_int   <= DEF_INT;
      pend_int  <= DEF_INT;
    end else begin
      os_tick_q <= wrap;

      if (both_restart) begin
        c <= '0;
      end else if (at_end) begin
        c <= '0;
        // The period just finished ran at the old divisor; swap in the new one.
        if (busy_q) act_int <= pend_int;
      end else begin
        c <= c + DIV_W'(1);
      end

      // A load on the wrap cycle still lands in pending for the next wrap.
      if (bus.i_div_load) begin
        pend_int <= bus.i_div_int;
        busy_q   <= 1'b1;
      end else if (wrap) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.o_os_tick  = os_tick_q;
  assign bus.o_div_busy = busy_q;

  baud_phase_ctr #(
    .OVERSAMPLE (OVERSAMPLE),
    .HIT_POINT  (OVERSAMPLE - 1)
  ) u_tx_phase (
    .i_clk   (i_clk),
    .reset   (reset),
    .restart (bus.i_tx_restart),
    .os_tick (wrap),
    .hit     (bus.o_tx_tick)
  );

  baud_phase_ctr #(
    .OVERSAMPLE (OVERSAMPLE),
    .HIT_POINT  (OVERSAMPLE / 2 - 1)
  ) u_rx_phase (
    .i_clk   (i_clk),
    .reset   (reset),
    .restart (bus.i_rx_restart),
    .os_tick (wrap),
    .hit     (bus.o_rx_sample)
  );

endmodule

// File: doc/baud_gen_os.md
Name: baud_gen_os

Overview:
Parametrised successor to the fixed-divisor baud tick generator. Produces a runtime-programmable oversampling tick with a fractional divisor, plus two derived tick streams. The TX stream gives one tick per bit. The RX stream gives a mid-bit sample tick. Each stream has its own independently restartable phase counter. It sits between the UART register block (which supplies the divisor) and the uart_tx / uart_rx FSMs.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- BAUDRATE, 921600, reset-time baud rate; used only to compute the default divisor.
- OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4.
- DIV_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor.

Ports:
- i_clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- i_div_int, in, DIV_W, integer clocks per oversample tick.
- i_div_frac, in, FRAC_W, fractional part, in units of 1/2^FRAC_W clock.
- i_div_load, in, 1, one-cycle strobe; captures i_div_int/i_div_frac into the pending register.
- i_tx_restart, in, 1, clears the TX phase counter.
- i_rx_restart, in, 1, clears the RX phase counter (driven on the start-bit edge).
- o_os_tick, out, 1, oversample tick; one-cycle pulse.
- o_tx_tick, out, 1, bit tick; one pulse per OVERSAMPLE os ticks.
- o_rx_sample, out, 1, mid-bit sample pulse.
- o_div_busy, out, 1, high while a loaded divisor is pending and not yet active.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-high, named reset.
- Outputs on reset: all outputs 0.
- Counter state on reset: period counter, fractional accumulator, TX phase and RX phase all 0.
- Divisor registers on reset: active and pending divisors both set to the defaults.
  - DEF_INT = CLK_HZ / (BAUDRATE*OVERSAMPLE).
  - DEF_FRAC = (CLK_HZ*2^FRAC_W / (BAUDRATE*OVERSAMPLE)) mod 2^FRAC_W.
  - Compute both with 64-bit arithmetic.
  - Elaboration error if DEF_INT < 2 or DEF_INT >= 2^DIV_W.
- Period counter: c counts 0..P-1.
  - Registered o_os_tick is 1 in the cycle after c == P-1, matching the legacy tick timing.
  - The first tick after reset release (cycle 0 = first non-reset cycle) appears at cycle P.
- Period length: P = div_int + carry.
  - carry is the overflow of acc + div_frac, evaluated when c == P-1. acc then takes the FRAC_W-bit sum.
  - Long-term average period = div_int + div_frac/2^FRAC_W.
- Divisor clamp: an active div_int < 2 is treated as 2.
- Divisor load:
  - i_div_load writes the pending register and sets o_div_busy in the next cycle.
  - The pending divisor becomes active at the wrap of the current period. Busy clears in the same cycle that o_os_tick pulses.
  - The current period always completes at the old divisor.
  - A second load while busy overwrites the pending value; no loss of ordering.
- TX phase: 0..OVERSAMPLE-1, incremented on each period wrap.
  - o_tx_tick pulses coincident with o_os_tick when the pre-increment TX phase == OVERSAMPLE-1.
- RX phase: same counting as TX.
  - o_rx_sample pulses coincident with o_os_tick when the pre-increment RX phase == OVERSAMPLE/2-1.
  - First sample is therefore at the OVERSAMPLE/2-th os tick after restart, then every OVERSAMPLE os ticks.
- Single restart: i_tx_restart or i_rx_restart clears only its own phase counter to 0.
  - If that phase would have produced a tick in the same cycle, restart wins and the tick is suppressed.
  - o_os_tick is unaffected.
- Both restarts in the same cycle (legacy behaviour): also clears the period counter and acc. No o_os_tick that cycle.
- Reset mid-operation: aborts everything. Outputs are 0 in the following cycle, and any pending load is discarded.

Optional Feature:
- Macro: BAUD_GEN_FRAC_EN.
- Defined: fractional accumulator present; behaviour exactly as above.
- Undefined:
  - i_div_frac is ignored; acc and carry are absent (carry = 0).
  - Period is exactly div_int.
  - DEF_FRAC is unused.
  - Ports are unchanged.

Decomposition:
- Package baud_pkg:
  - typedef baud_div_t, a struct {int_part, frac_part}.
  - Function computing the default divisor from CLK_HZ, BAUDRATE, OVERSAMPLE, FRAC_W.
  - localparam OVERSAMPLE_DEFAULT = 16.
- Sub-module baud_phase_ctr:
  - Parameters OVERSAMPLE and HIT_POINT.
  - Inputs i_clk, reset, restart, os_tick.
  - Output hit.
  - Instantiated twice: TX with HIT_POINT = OVERSAMPLE-1, RX with HIT_POINT = OVERSAMPLE/2-1.

Test Plan:
- Defaults (100 MHz, 921600): active divisor is 6 + 12/16.
  - Os-tick periods repeat the pattern 6,7,7,7.
  - Exactly one o_tx_tick every 108 cycles over 10 bits.
  - With BAUD_GEN_FRAC_EN undefined: o_tx_tick every 96 cycles.
- Load int=10, frac=0 at c=3 of a 7-cycle period:
  - Current period ends at 7 with busy high.
  - Busy drops with that tick.
  - Subsequent ticks every 10 cycles.
- Load int=1, frac=0: os tick every 2 cycles. Load int=0: same.
- Pulse i_rx_restart at an arbitrary cycle:
  - o_rx_sample on the 8th os tick after restart, then on every 16th.
  - o_tx_tick spacing is unchanged.
- Restart collisions:
  - i_tx_restart in the cycle its wrap would fire: no o_tx_tick; next tx tick 16 os ticks later.
  - Both restarts together: no os tick that cycle; next os tick exactly P cycles later.
- Reset asserted mid-period with a load pending:
  - All outputs 0 the next cycle.
  - After release, timing matches the default divisor; the pending divisor is never applied.
